// File: rtl/d_not_pipe_if.sv
// Handshake bundle for d_not_pipe: producer side (in_*, inv_en) and consumer side (out_*, occ).
interface d_not_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             inv_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occ;

    modport master (
        output in_valid, in_data, inv_en, out_ready,
        input  in_ready, out_valid, out_data, occ
    );

    modport slave (
        input  in_valid, in_data, inv_en, out_ready,
        output in_ready, out_valid, out_data, occ
    );
endinterface

// File: rtl/d_not_pipe.sv
// WIDTH-bit, DEPTH-stage elastic register pipeline; beats are optionally
// complemented under INV_MASK at capture and travel with full backpressure.
module d_not_pipe #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 3,
    parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b1}}
) (
    input logic        clk,
    input logic        rst,
    d_not_pipe_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [OCC_W-1:0] occ;
    logic             in_fire;
    logic             out_fire;

    // A stage may load when something downstream of it (or the consumer)
    // has room; the running OR keeps this a simple tail-to-head chain.
    always_comb begin
        logic room;
        // NOTE: every variable written here is given a value on every path,
        // so no latch can be inferred.
        room = bus.out_ready;
        rdy  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            room   = room | ~v[i];
            rdy[i] = room;
        end
    end

    assign bus.in_ready  = rdy[0] & ~rst;
    assign in_fire       = bus.in_valid & bus.in_ready;
    assign out_fire      = v[DEPTH-1] & bus.out_ready;
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];
    assign bus.occ       = occ;

    // NOTE: all state uses non-blocking assignments so every stage samples
    // its upstream neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            v   <= '0;
            occ <= '0;
            // NOTE: the data array is cleared too, so out_data reads 0 out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    d[0] <= bus.inv_en ? (bus.in_data ^ INV_MASK) : bus.in_data;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        d[i] <= d[i-1];
                    end
                end
            end
            case ({in_fire, out_fire})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_d_not_pipe.sv
// Directed bench for d_not_pipe with a scoreboard queue of expected beats.
module tb_d_not_pipe;
    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] MASK  = 8'hFF;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] sb[$];

    d_not_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    d_not_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INV_MASK(MASK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check handshake/occupancy against the model, update the
    // scoreboard for this cycle's transfers, then advance past the edge.
    task automatic step();
        logic exp_rdy;
        #1;
        if (rst) begin
            check("in_ready_in_rst", {31'd0, bus.in_ready}, 32'd0);
        end else begin
            exp_rdy = (sb.size() < DEPTH) || bus.out_ready;
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
            check("occ", {30'd0, bus.occ}, sb.size());
            if (sb.size() == 0) begin
                check("no_stale_beat", {31'd0, bus.out_valid}, 32'd0);
            end else if (bus.out_valid && bus.out_ready) begin
                check("out_data", {24'd0, bus.out_data}, {24'd0, sb[0]});
                void'(sb.pop_front());
            end
            if (bus.in_valid && exp_rdy) begin
                sb.push_back(bus.inv_en ? (bus.in_data ^ MASK) : bus.in_data);
            end
        end
        @(posedge clk);
        if (rst) sb.delete();
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hA5;
        bus.inv_en    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset with a beat offered: nothing may enter.
        repeat (3) step();
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        check("rst_occ", {30'd0, bus.occ}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

        // Latency and inversion: 3C inverted emerges as C3 after DEPTH-1 more edges.
        bus.in_valid = 1'b1; bus.in_data = 8'h3C; bus.inv_en = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("lat_valid_n", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("lat_valid_n1", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("lat_valid_n2", {31'd0, bus.out_valid}, 32'd1);
        check("lat_data", {24'd0, bus.out_data}, 32'hC3);
        step();
        check("lat_one_cycle", {31'd0, bus.out_valid}, 32'd0);

        // Mode travels with each beat.
        bus.in_valid = 1'b1;
        bus.in_data = 8'h00; bus.inv_en = 1'b1; step();
        bus.in_data = 8'h00; bus.inv_en = 1'b0; step();
        bus.in_data = 8'hF0; bus.inv_en = 1'b1; step();
        bus.in_valid = 1'b0; bus.inv_en = 1'b0;
        check("mode_v0", {31'd0, bus.out_valid}, 32'd1);
        check("mode_d0", {24'd0, bus.out_data}, 32'hFF);
        step();
        check("mode_v1", {31'd0, bus.out_valid}, 32'd1);
        check("mode_d1", {24'd0, bus.out_data}, 32'h00);
        step();
        check("mode_v2", {31'd0, bus.out_valid}, 32'd1);
        check("mode_d2", {24'd0, bus.out_data}, 32'h0F);
        step();
        check("mode_end", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: three fit, the fourth waits until the consumer frees a slot.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            bus.in_data = 8'(k);
            step();
        end
        bus.in_data = 8'h04;
        check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("full_occ", {30'd0, bus.occ}, 32'd3);
        step();
        bus.out_ready = 1'b1;
        #1;
        check("full_ready_release", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        check("drain_occ", {30'd0, bus.occ}, 32'd0);

        // Full pipeline with transfers in and out every cycle.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_data = 8'h10 + 8'(k);
            step();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.in_data = 8'h20 + 8'(k);
            step();
            check("stream_occ", {30'd0, bus.occ}, 32'd3);
        end
        bus.in_valid = 1'b0;
        repeat (4) step();
        check("stream_drain_occ", {30'd0, bus.occ}, 32'd0);

        // Mid-operation reset discards in-flight beats.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data = 8'hA1; step();
        bus.in_data = 8'hA2; step();
        bus.in_valid = 1'b0;
        check("pre_rst_occ", {30'd0, bus.occ}, 32'd2);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_occ", {30'd0, bus.occ}, 32'd0);
        repeat (5) step();

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
